// File: rtl/rom_fetch_master.sv
// rom_fetch_master
//   Free-running 8-phase nibble-bus fetch master. Every instruction cycle
//   runs A1..X3 regardless of traffic; a request accepted on the last clock
//   of X3 makes the following cycle an active fetch of one ROM byte.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high reset
//   req_valid  fetch request present (held until accepted)
//   req_addr   12-bit ROM address: [11:8] chip, [7:0] byte
//   req_ready  high on the last clock of X3 only (acceptance point)
//   rsp_valid  one-clock pulse on the first clock of X1 of an active cycle
//   rsp_data   fetched byte {M1 nibble, M2 nibble}, held until next response
//   bus_out    nibble driven onto the shared bus (0 when not driving)
//   bus_oe     drive enable for bus_out (A1..A3 of active cycles)
//   bus_in     sampled bus value
//   sync       high throughout X3
//   cm_rom     ROM chip-select strobe, A3 of active cycles
//
// phase | meaning
// A1    | drive addr[3:0]
// A2    | drive addr[7:4]
// A3    | drive addr[11:8], cm_rom strobe
// M1    | ROM returns high nibble, sampled on last clock
// M2    | ROM returns low nibble, sampled on last clock
// X1    | response pulse on first clock
// X2    | execute, bus idle
// X3    | sync; request accepted on last clock

module rom_fetch_master #(
  parameter int CYCLES_PER_PHASE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [11:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [3:0]  bus_out,
  output logic        bus_oe,
  input  logic [3:0]  bus_in,
  output logic        sync,
  output logic        cm_rom
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  localparam logic [3:0] SUB_LAST = 4'(CYCLES_PER_PHASE - 1);

  phase_t      phase, phase_nxt;
  logic [3:0]  sub, sub_nxt;
  logic        active, active_nxt;
  logic [11:0] addr, addr_nxt;
  logic [3:0]  hi_nib;
  logic        sub_last;
  logic        accept;

  // Next-state view; registered outputs are decoded from it so they line up
  // with the phase they describe instead of lagging by one clock.
  always_comb begin
    sub_last   = (sub == SUB_LAST);
    accept     = req_valid && req_ready;
    phase_nxt  = phase;
    sub_nxt    = sub + 4'd1;
    active_nxt = active;
    addr_nxt   = addr;
    if (sub_last) begin
      sub_nxt   = 4'd0;
      phase_nxt = phase_t'(3'(phase + 3'd1));
      if (phase == PH_X3) begin
        active_nxt = accept;
        if (accept) addr_nxt = req_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= PH_X3;
      sub       <= SUB_LAST;
      active    <= 1'b0;
      addr      <= 12'h000;
      hi_nib    <= 4'h0;
      sync      <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      bus_out   <= 4'h0;
      bus_oe    <= 1'b0;
      cm_rom    <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      sub    <= sub_nxt;
      active <= active_nxt;
      addr   <= addr_nxt;

      sync      <= (phase_nxt == PH_X3);
      req_ready <= (phase_nxt == PH_X3) && (sub_nxt == SUB_LAST);
      bus_oe    <= active_nxt && (phase_nxt inside {PH_A1, PH_A2, PH_A3});
      cm_rom    <= active_nxt && (phase_nxt == PH_A3);

      if (active_nxt) begin
        case (phase_nxt)
          PH_A1:   bus_out <= addr_nxt[3:0];
          PH_A2:   bus_out <= addr_nxt[7:4];
          PH_A3:   bus_out <= addr_nxt[11:8];
          default: bus_out <= 4'h0;
        endcase
      end else begin
        bus_out <= 4'h0;
      end

      // High nibble is staged so rsp_data only changes together with
      // rsp_valid and otherwise holds the previous response.
      if (active && sub_last && (phase == PH_M1)) hi_nib <= bus_in;

      rsp_valid <= 1'b0;
      if (active && sub_last && (phase == PH_M2)) begin
        rsp_data  <= {hi_nib, bus_in};
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_master.sv
module tb_rom_fetch_master;

  localparam int CPP0 = 1;
  localparam int CPP1 = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset     [2];
  logic        req_valid [2];
  logic [11:0] req_addr  [2];
  logic [3:0]  bus_in    [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_data  [2];
  logic [3:0]  bus_out   [2];
  logic        bus_oe    [2];
  logic        sync      [2];
  logic        cm_rom    [2];

  int n_cmp = 0;
  int n_bad = 0;

  rom_fetch_master #(.CYCLES_PER_PHASE(CPP0)) dut0 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]), .sync(sync[0]),
    .cm_rom(cm_rom[0]));

  rom_fetch_master #(.CYCLES_PER_PHASE(CPP1)) dut1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]), .sync(sync[1]),
    .cm_rom(cm_rom[1]));

  task automatic check(input string name, input int d, input logic [15:0] got,
                       input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", name, d, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: position in the instruction cycle is derived purely from
  // the clock count since reset release (t), the phase length and the cycle
  // length; per-cycle activity and the response byte are tracked as facts.
  int          m_t    [2];
  bit          m_rst  [2];
  bit          m_act  [2];
  logic [11:0] m_addr [2];
  logic [3:0]  m_hi   [2];
  logic [7:0]  m_data [2];

  int   cpp, ph, sb;
  bit   e_sync, e_rdy, e_oe, e_cm, e_rv;
  logic [3:0] e_bus;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_rst[d] = 1'b1; m_t[d] = 0; m_act[d] = 1'b0;
      m_addr[d] = '0; m_hi[d] = '0; m_data[d] = '0;
    end
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        cpp = (d == 0) ? CPP0 : CPP1;
        ph  = (m_t[d] / cpp) % 8;
        sb  = m_t[d] % cpp;
        if (m_rst[d]) begin
          e_sync = 1'b1; e_rdy = 1'b0; e_oe = 1'b0; e_cm = 1'b0; e_rv = 1'b0; e_bus = 4'h0;
        end else begin
          e_sync = (ph == 7);
          e_rdy  = (ph == 7) && (sb == cpp - 1);
          e_oe   = m_act[d] && (ph < 3);
          e_cm   = m_act[d] && (ph == 2);
          e_rv   = m_act[d] && (ph == 5) && (sb == 0);
          e_bus  = !e_oe ? 4'h0 : (ph == 0) ? m_addr[d][3:0] :
                   (ph == 1) ? m_addr[d][7:4] : m_addr[d][11:8];
        end
        check("sync",      d, 16'(sync[d]),      16'(e_sync));
        check("req_ready", d, 16'(req_ready[d]), 16'(e_rdy));
        check("bus_oe",    d, 16'(bus_oe[d]),    16'(e_oe));
        check("bus_out",   d, 16'(bus_out[d]),   16'(e_bus));
        check("cm_rom",    d, 16'(cm_rom[d]),    16'(e_cm));
        check("rsp_valid", d, 16'(rsp_valid[d]), 16'(e_rv));
        check("rsp_data",  d, 16'(rsp_data[d]),  16'(m_data[d]));

        // advance with the inputs the coming edge will see
        if (reset[d]) begin
          m_rst[d] = 1'b1; m_act[d] = 1'b0; m_data[d] = 8'h00;
        end else if (m_rst[d]) begin
          m_rst[d] = 1'b0; m_t[d] = 0; m_act[d] = 1'b0;
        end else begin
          if (m_act[d] && ph == 3 && sb == cpp - 1) m_hi[d] = bus_in[d];
          if (m_act[d] && ph == 4 && sb == cpp - 1) m_data[d] = {m_hi[d], bus_in[d]};
          if (ph == 7 && sb == cpp - 1) begin
            m_act[d] = req_valid[d];
            if (req_valid[d]) m_addr[d] = req_addr[d];
          end
          m_t[d]++;
        end
      end
    end
  end

  task automatic rand_run(input int d, input int n);
    logic rdy;
    int   rst_cnt;
    rdy = 1'b0;
    rst_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (rst_cnt > 0) rst_cnt--;
      else begin
        reset[d] = 1'b0;
        if ($urandom_range(199) == 0) begin
          reset[d] = 1'b1;
          rst_cnt = $urandom_range(2);
        end
      end
      if (!req_valid[d] || rdy) begin
        req_valid[d] = ($urandom_range(2) != 0);
        req_addr[d]  = 12'($urandom);
      end
      bus_in[d] = 4'($urandom);
      @(negedge clock);
      rdy = req_ready[d];
      tick();
    end
    reset[d] = 1'b0;
  endtask

  task automatic start(input int d);
    reset[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; bus_in[d] = '0;
    tick(); tick();
    reset[d] = 1'b0;
    tick();
  endtask

  // CYCLES_PER_PHASE = 1: directed scenarios, then random traffic
  task automatic stim0();
    start(0);
    for (int g = 0; g < 80; g++) begin
      bus_in[0] = 4'($urandom);
      if (g == 16) begin req_valid[0] = 1'b1; req_addr[0] = 12'h3A5; end
      if (g == 24) req_valid[0] = 1'b0;
      if (g >= 24 && g <= 34) req_addr[0] = 12'($urandom);
      if (g == 27) bus_in[0] = 4'hD;
      if (g == 28) bus_in[0] = 4'h2;
      if (g == 35) begin req_valid[0] = 1'b1; req_addr[0] = 12'h000; end
      if (g == 40) req_addr[0] = 12'hFFF;
      if (g == 48) begin req_valid[0] = 1'b0; req_addr[0] = 12'($urandom); end
      if (g == 55) begin req_valid[0] = 1'b1; req_addr[0] = 12'h5C7; end
      if (g == 60) reset[0] = 1'b1;
      if (g == 62) reset[0] = 1'b0;
      if (g == 71) req_valid[0] = 1'b0;
      @(negedge clock);
      if (g < 16) begin
        check("idle_sync", 0, 16'(sync[0]), 16'((g == 7) || (g == 15)));
        check("idle_oe",   0, 16'(bus_oe[0]), 16'h0);
      end
      if (g == 22) check("rdy_early", 0, 16'(req_ready[0]), 16'h0);
      if (g == 23) check("rdy_x3",    0, 16'(req_ready[0]), 16'h1);
      if (g == 24) check("a1_nib",    0, 16'(bus_out[0]), 16'h5);
      if (g == 25) check("a2_nib",    0, 16'(bus_out[0]), 16'hA);
      if (g == 26) check("a3_nib",    0, 16'(bus_out[0]), 16'h3);
      if (g == 26) check("a3_cm",     0, 16'(cm_rom[0]), 16'h1);
      if (g == 29) check("rsp_pulse", 0, 16'(rsp_valid[0]), 16'h1);
      if (g == 29) check("rsp_d2",    0, 16'(rsp_data[0]), 16'hD2);
      if (g == 30) check("rsp_hold",  0, 16'(rsp_data[0]), 16'hD2);
      if (g >= 35 && g <= 38) check("m1_wait", 0, 16'(req_ready[0]), 16'h0);
      if (g >= 35 && g <= 39) check("m1_no_oe", 0, 16'(bus_oe[0]), 16'h0);
      if (g == 39) check("m1_ack", 0, 16'(req_ready[0]), 16'h1);
      if (g >= 40 && g <= 42) check("nib_000", 0, 16'({bus_oe[0], bus_out[0]}), 16'h10);
      if (g >= 48 && g <= 50) check("nib_fff", 0, 16'({bus_oe[0], bus_out[0]}), 16'h1F);
      if (g == 45 || g == 53) check("b2b_rsp", 0, 16'(rsp_valid[0]), 16'h1);
      if (g == 49) check("b2b_gap", 0, 16'(rsp_valid[0]), 16'h0);
      if (g == 61) check("abort_rv", 0, 16'(rsp_valid[0]), 16'h0);
      if (g == 62) check("rst_state", 0,
                         16'({sync[0], req_ready[0], bus_oe[0], cm_rom[0], rsp_data[0]}), 16'h800);
      if (g == 63) check("post_idle", 0, 16'({sync[0], bus_oe[0]}), 16'h0);
      if (g == 70) check("post_ack", 0, 16'(req_ready[0]), 16'h1);
      if (g == 71) check("post_act", 0, 16'({bus_oe[0], bus_out[0]}), 16'h17);
      tick();
    end
    rand_run(0, 720);
  endtask

  // CYCLES_PER_PHASE = 3: one fetch with phase-length checks, then random
  task automatic stim1();
    start(1);
    for (int g = 0; g < 48; g++) begin
      bus_in[1] = 4'($urandom);
      if (g == 0)  begin req_valid[1] = 1'b1; req_addr[1] = 12'h7E4; end
      if (g == 24) req_valid[1] = 1'b0;
      if (g == 33 || g == 34) bus_in[1] = 4'h1;
      if (g == 35) bus_in[1] = 4'h9;
      if (g == 36 || g == 37) bus_in[1] = 4'h3;
      if (g == 38) bus_in[1] = 4'h6;
      @(negedge clock);
      if (g == 20) check("p3_sync0", 1, 16'(sync[1]), 16'h0);
      if (g == 21) check("p3_sync1", 1, 16'(sync[1]), 16'h1);
      if (g == 22) check("p3_rdy0",  1, 16'(req_ready[1]), 16'h0);
      if (g == 23 || g == 47) check("p3_rdy1", 1, 16'(req_ready[1]), 16'h1);
      if (g >= 24 && g <= 26) check("p3_a1", 1, 16'(bus_out[1]), 16'h4);
      if (g >= 27 && g <= 29) check("p3_a2", 1, 16'(bus_out[1]), 16'hE);
      if (g >= 30 && g <= 32) check("p3_a3", 1, 16'({cm_rom[1], bus_out[1]}), 16'h17);
      if (g == 33) check("p3_oe_off", 1, 16'(bus_oe[1]), 16'h0);
      if (g == 38 || g == 40) check("p3_rv0", 1, 16'(rsp_valid[1]), 16'h0);
      if (g == 39) check("p3_rv1", 1, 16'({rsp_valid[1], rsp_data[1]}), 16'h196);
      tick();
    end
    rand_run(1, 350);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      stim0();
      stim1();
    join
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
